// File: rtl/mux_4_1_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux_4_1_rr_arbiter_if
// Bundle of request, mux data and grant/select signals exchanged between the
// four requesting sources (master side) and the round-robin arbiter that owns
// the 4:1 mux select (slave side).
// ---------------------------------------------------------------------------
interface mux_4_1_rr_arbiter_if;

    logic [3:0] req;      // one request line per source
    logic [3:0] data_in;  // mux data inputs I[0..3]
    logic [3:0] gnt;      // one-hot grant, zero when idle
    logic [1:0] sel;      // binary mux select, index of the gnt bit
    logic       valid;    // a grant is active
    logic       y;        // registered, gated mux output

    // Requesting side: drives requests and data, observes the grant.
    modport master (
        output req,
        output data_in,
        input  gnt,
        input  sel,
        input  valid,
        input  y
    );

    // Arbiter side: consumes requests and data, produces the grant.
    modport slave (
        input  req,
        input  data_in,
        output gnt,
        output sel,
        output valid,
        output y
    );

endinterface : mux_4_1_rr_arbiter_if

// File: rtl/mux_4_1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_4_1_rr_arbiter
// Round-robin arbiter that shares a single 4:1 mux among four requesters.
// It drives a registered one-hot grant, a registered binary select, a valid
// flag and a registered, gated copy of the selected data bit.
//
// Optional feature, macro ARB_TIMEOUT_EN:
//   defined   - a grantee holding the mux for HOLD_MAX consecutive cycles is
//               forced to hand over when another source is requesting.
//   undefined - no hold counter; a grant lasts until its request drops.
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// ---------------------------------------------------------------------------
module mux_4_1_rr_arbiter #(
    parameter int RESET_PTR = 0,  // requester checked first after reset (0..3)
    parameter int HOLD_MAX  = 8   // max consecutive grant cycles (timeout build)
) (
    input  logic                  clk,
    input  logic                  rst,  // synchronous, active-high
    mux_4_1_rr_arbiter_if.slave   bus
);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // -----------------------------------------------------------------------
    if ((RESET_PTR < 0) || (RESET_PTR > 3) || (HOLD_MAX < 2)) begin : g_bad_param
        $error("mux_4_1_rr_arbiter: RESET_PTR must be 0..3 and HOLD_MAX >= 2");
    end

    localparam logic [1:0] RESET_PTR_V = 2'(RESET_PTR);

    // -----------------------------------------------------------------------
    // FSM encoding
    // -----------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Round-robin search: first set bit of req_v starting at index start,
    // wrapping modulo 4. Callers only use the result when req_v is non-zero.
    // -----------------------------------------------------------------------
    function automatic logic [1:0] rr_pick(input logic [3:0] req_v,
                                           input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] cand;
        logic       found;
        idx   = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = start + 2'(i);
            if (!found && req_v[cand]) begin
                idx   = cand;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return idx;
    endfunction

    // One-hot decode of a 2-bit index.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] oh;
        oh      = 4'b0000;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [3:0] gnt_q,   gnt_d;
    logic [1:0] sel_q,   sel_d;
    logic       valid_q, valid_d;
    logic       y_q,     y_d;

    // Decoded conditions used by the next-state logic.
    logic [3:0] others_s;    // requests other than the current grantee
    logic       release_s;   // current grantee dropped its request
    logic       timeout_s;   // grantee must yield because it held too long
    logic [1:0] pick_idx_s;  // arbitration winner for this edge
    logic [1:0] pick_start_s;
    logic [3:0] pick_req_s;

`ifdef ARB_TIMEOUT_EN
    localparam int             CNT_W     = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

    // Requests that compete with the current grantee.
    assign others_s  = bus.req & ~gnt_q;
    assign release_s = (state_q == ST_GRANT) && !bus.req[sel_q];

`ifdef ARB_TIMEOUT_EN
    // Forced yield only makes sense when somebody else is waiting.
    assign timeout_s = (state_q == ST_GRANT) && (hold_cnt_q == HOLD_LAST) &&
                       (others_s != 4'b0000);
`else
    assign timeout_s = 1'b0;
`endif

    // Select search vector and start point for the single arbitration search.
    always_comb begin
        pick_req_s   = bus.req;
        pick_start_s = ptr_q;
        if (state_q == ST_GRANT) begin
            // Handover searches just past the yielding grantee.
            pick_req_s   = others_s;
            pick_start_s = sel_q + 2'd1;
        end else begin
            pick_req_s   = bus.req;
            pick_start_s = ptr_q;
        end
    end

    assign pick_idx_s = rr_pick(pick_req_s, pick_start_s);

    // Next-state and grant logic for the IDLE/GRANT controller.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req != 4'b0000) begin
                    // Fresh grant from idle; pointer is left where it was.
                    state_d = ST_GRANT;
                    gnt_d   = onehot4(pick_idx_s);
                    sel_d   = pick_idx_s;
                    valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = 4'b0000;
                    sel_d   = 2'd0;
                    valid_d = 1'b0;
                end
            end

            ST_GRANT: begin
                if (release_s || timeout_s) begin
                    // Yielding source drops to lowest priority.
                    ptr_d = sel_q + 2'd1;
                    if (others_s != 4'b0000) begin
                        // Direct handover in the same edge, no idle bubble.
                        state_d = ST_GRANT;
                        gnt_d   = onehot4(pick_idx_s);
                        sel_d   = pick_idx_s;
                        valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt_d = '0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = 4'b0000;
                        sel_d   = 2'd0;
                        valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt_d = '0;
`endif
                    end
                end else begin
                    // Hold the grant; other request lines are ignored.
                    state_d = ST_GRANT;
                    gnt_d   = gnt_q;
                    sel_d   = sel_q;
                    valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    // Saturate so a lone requester keeps the grant forever.
                    if (hold_cnt_q != HOLD_LAST) begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end else begin
                        hold_cnt_d = hold_cnt_q;
                    end
`endif
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean idle state.
                state_d = ST_IDLE;
                ptr_d   = RESET_PTR_V;
                gnt_d   = 4'b0000;
                sel_d   = 2'd0;
                valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
                hold_cnt_d = '0;
`endif
            end
        endcase
    end

    // Gated data path uses the select that was valid before this edge.
    always_comb begin
        if (valid_q) begin
            y_d = bus.data_in[sel_q];
        end else begin
            y_d = 1'b0;
        end
    end

    // State, pointer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= RESET_PTR_V;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            valid_q <= 1'b0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            y_q     <= y_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Consecutive-grant counter for the forced handover.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    // Outputs are driven directly from flops.
    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.valid = valid_q;
    assign bus.y     = y_q;

endmodule : mux_4_1_rr_arbiter

// File: tb/tb_mux_4_1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_4_1_rr_arbiter
// Directed, table-driven bench for the round-robin mux arbiter, followed by
// a hand-written sequence for the long-hold / timeout behaviour.
// ---------------------------------------------------------------------------
module tb_mux_4_1_rr_arbiter;

    localparam int TB_HOLD = 8;
    localparam int NVEC    = 26;

    logic clk;
    logic rst;

    mux_4_1_rr_arbiter_if bus();

    mux_4_1_rr_arbiter #(
        .RESET_PTR (0),
        .HOLD_MAX  (TB_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] data;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       y;
    } vec_t;

    vec_t vecs [NVEC];

    int checks;
    int failures;

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    // Apply inputs away from the edge, let one rising edge pass, sample #1 after.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] d);
        @(negedge clk);
        rst         = r;
        bus.req     = rq;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_gnt;
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        bus.req     = 4'b0000;
        bus.data_in = 4'b0000;

        //            rst   req      data     gnt      sel   valid y
        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // reset
        vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // reset
        vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0}; // first grant
        vecs[3]  = '{1'b0, 4'b1110, 4'b0001, 4'b0010, 2'd1, 1'b1, 1'b1}; // rotate
        vecs[4]  = '{1'b0, 4'b1101, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4'b1011, 4'b0100, 4'b1000, 2'd3, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 4'b0111, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b1}; // wrap
        vecs[7]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0}; // to src2
        vecs[8]  = '{1'b0, 4'b0101, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1}; // hold
        vecs[9]  = '{1'b0, 4'b1100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 4'b1100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 4'b1001, 4'b0100, 4'b1000, 2'd3, 1'b1, 1'b1}; // release
        vecs[13] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0}; // src1
        vecs[14] = '{1'b0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1}; // data
        vecs[15] = '{1'b0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 4'b0000, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b1}; // y lags
        vecs[18] = '{1'b0, 4'b0000, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0}; // idle
        vecs[19] = '{1'b0, 4'b0010, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0}; // fresh
        vecs[20] = '{1'b0, 4'b0010, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[21] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0}; // src3
        vecs[22] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // idle
        vecs[23] = '{1'b0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0}; // ptr=0
        vecs[24] = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0}; // reset drop
        vecs[25] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].data);
            check("gnt",   i, {4'b0000, bus.gnt},    {4'b0000, vecs[i].gnt});
            check("sel",   i, {6'b000000, bus.sel},  {6'b000000, vecs[i].sel});
            check("valid", i, {7'b0000000, bus.valid}, {7'b0000000, vecs[i].valid});
            check("y",     i, {7'b0000000, bus.y},   {7'b0000000, vecs[i].y});
        end

        // Long hold with two contenders: no change without the timeout build,
        // alternation every TB_HOLD cycles with it.
        step(1'b1, 4'b0000, 4'b0000);
        for (int k = 1; k <= 3 * TB_HOLD; k++) begin
            step(1'b0, 4'b0011, 4'b0000);
`ifdef ARB_TIMEOUT_EN
            exp_gnt = ((((k - 1) / TB_HOLD) % 2) == 0) ? 4'b0001 : 4'b0010;
`else
            exp_gnt = 4'b0001;
`endif
            check("hold2_gnt", k, {4'b0000, bus.gnt}, {4'b0000, exp_gnt});
        end

        // Lone requester keeps the grant indefinitely in either build.
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 4'b0001, 4'b0001);
            check("lone_gnt", k, {4'b0000, bus.gnt}, 8'h01);
        end
        check("lone_y", 0, {7'b0000000, bus.y}, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux_4_1_rr_arbiter
